// File: rtl/vnlp_host_seq_if.sv
// Host/engine/result signal bundle for vnlp_host_seq.
// The master modport is the sequencer; the slave modport is the host plus engine side.
interface vnlp_host_seq_if #(
    parameter int DATA_W = 19
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mem_we;
    logic [8:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              vnlp_start;
    logic              vnlp_done;
    logic [27:0]       vnlp_sum;
    logic [8:0]        vnlp_len;
    logic              res_valid;
    logic              res_ready;
    logic [27:0]       res_sum;
    logic [8:0]        res_len;
    logic [9:0]        res_words;
    logic              res_trunc;
    logic              res_timeout;

    modport master (
        input  in_valid, in_data, in_last, vnlp_done, vnlp_sum, vnlp_len, res_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, vnlp_start,
               res_valid, res_sum, res_len, res_words, res_trunc, res_timeout
    );

    modport slave (
        output in_valid, in_data, in_last, vnlp_done, vnlp_sum, vnlp_len, res_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, vnlp_start,
               res_valid, res_sum, res_len, res_words, res_trunc, res_timeout
    );
endinterface

// File: rtl/vnlp_host_seq.sv
// Host-side sequencer: streams operands into the VNLP operand memory, starts the engine,
// waits for done (with timeout) and hands the latched result record back to the host.
module vnlp_host_seq #(
    parameter int DATA_W  = 19,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    vnlp_host_seq_if.master   bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_RESULT} state_t;

    state_t        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [27:0]   sum_q, sum_d;
    logic [8:0]    len_q, len_d;
    logic          trunc_q, trunc_d;
    logic          tout_q, tout_d;

    logic              in_ready_c, mem_we_c, start_c, res_valid_c;
    logic [8:0]        mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            sum_q   <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            sum_q   <= sum_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        sum_d       = sum_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        tout_d      = tout_q;
        in_ready_c  = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        start_c     = 1'b0;
        res_valid_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    mem_we_c    = 1'b1;
                    mem_addr_c  = cnt_q[8:0];
                    mem_wdata_c = bus.in_data;
                    cnt_d       = cnt_q + 10'd1;
                    // Address 511 is the last slot, so the run ends there even without in_last.
                    if (bus.in_last || cnt_q == 10'd511) begin
                        trunc_d = ~bus.in_last;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                start_c = 1'b1;
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // tcnt_q==0 marks the first WAIT cycle, where done may still be left over.
                if (tcnt_q != '0 && bus.vnlp_done) begin
                    sum_d   = bus.vnlp_sum;
                    len_d   = bus.vnlp_len;
                    state_d = S_RESULT;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    sum_d   = '0;
                    len_d   = '0;
                    state_d = S_RESULT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_RESULT: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    trunc_d = 1'b0;
                    tout_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.vnlp_start  = start_c;
    assign bus.res_valid   = res_valid_c;
    assign bus.res_sum     = sum_q;
    assign bus.res_len     = len_q;
    assign bus.res_words   = cnt_q;
    assign bus.res_trunc   = trunc_q;
    assign bus.res_timeout = tout_q;
endmodule

// File: tb/tb_vnlp_host_seq.sv
// Directed bench for vnlp_host_seq: engine model, per-cycle phase model checker and
// literal result checks per scenario.
module tb_vnlp_host_seq;
    localparam int DW = 19;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vnlp_host_seq_if #(.DATA_W(DW)) bus();
    vnlp_host_seq #(.DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Engine model: sums the words written since the last start; done is a level that stays
    // high until the next start (optionally held one extra cycle to mimic a stale done).
    int          eng_delay = 10;
    bit          stale_mode = 1'b0;
    bit          eng_busy = 1'b0;
    int          eng_t = 0;
    logic [27:0] acc_sum = '0, pend_sum = '0;
    int          acc_n = 0, pend_n = 0;
    logic        eng_done = 1'b0;
    logic [27:0] eng_sum = '0;
    logic [8:0]  eng_len = '0;
    assign bus.vnlp_done = eng_done;
    assign bus.vnlp_sum  = eng_sum;
    assign bus.vnlp_len  = eng_len;

    always @(posedge clk) begin
        if (bus.vnlp_start) begin
            pend_sum = acc_sum;
            pend_n   = acc_n;
            acc_sum  = '0;
            acc_n    = 0;
            eng_busy = (eng_delay != 0);
            eng_t    = 1;
            if (!stale_mode) eng_done <= 1'b0;
        end else if (eng_busy) begin
            if (eng_t == eng_delay) begin
                eng_done <= 1'b1;
                eng_sum  <= pend_sum;
                eng_len  <= 9'(pend_n);
                eng_busy = 1'b0;
            end else if (eng_t == 1) begin
                eng_done <= 1'b0;
            end
            eng_t++;
        end
        if (bus.mem_we) begin
            acc_sum = acc_sum + 28'(bus.mem_wdata);
            acc_n++;
        end
    end

    // Phase model: 0 idle, 1 load, 2 start, 3 wait, 4 result.
    int          ph = 0;
    bit          armed = 1'b0, post_rst = 1'b0;
    int          m_cnt = 0, wcyc = 0;
    logic [27:0] m_sum = '0, e_sum = '0;
    logic [8:0]  e_len = '0;
    bit          m_trunc = 1'b0, m_to = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            armed = 1'b1; post_rst = 1'b1; ph = 0;
        end else if (armed) begin
            if (post_rst) begin
                chk("rst_outputs", {bus.in_ready, bus.mem_we, bus.vnlp_start, bus.res_valid,
                                    bus.res_trunc, bus.res_timeout}, 0);
                chk("rst_res_sum", bus.res_sum, 0);
                chk("rst_res_len", bus.res_len, 0);
                chk("rst_res_words", bus.res_words, 0);
                chk("rst_mem_addr", bus.mem_addr, 0);
                post_rst = 1'b0;
            end
            case (ph)
                0: begin
                    chk("idle_ready", bus.in_ready, 0);
                    chk("idle_we", bus.mem_we, 0);
                    chk("idle_start", bus.vnlp_start, 0);
                    chk("idle_res_valid", bus.res_valid, 0);
                    m_cnt = 0; m_sum = '0; ph = 1;
                end
                1: begin
                    chk("load_ready", bus.in_ready, 1);
                    chk("load_start", bus.vnlp_start, 0);
                    chk("load_res_valid", bus.res_valid, 0);
                    chk("load_we", bus.mem_we, bus.in_valid);
                    if (bus.in_valid) begin
                        chk("load_addr", bus.mem_addr, m_cnt);
                        chk("load_wdata", bus.mem_wdata, bus.in_data);
                        m_sum = m_sum + 28'(bus.in_data);
                        m_cnt++;
                        if (bus.in_last || m_cnt == 512) begin
                            m_trunc = !bus.in_last; ph = 2;
                        end
                    end
                end
                2: begin
                    chk("start_pulse", bus.vnlp_start, 1);
                    chk("start_ready", bus.in_ready, 0);
                    chk("start_we", bus.mem_we, 0);
                    chk("start_res_valid", bus.res_valid, 0);
                    wcyc = 0; ph = 3;
                end
                3: begin
                    wcyc++;
                    chk("wait_start", bus.vnlp_start, 0);
                    chk("wait_ready", bus.in_ready, 0);
                    chk("wait_we", bus.mem_we, 0);
                    chk("wait_res_valid", bus.res_valid, 0);
                    if (wcyc > 1 && bus.vnlp_done) begin
                        e_sum = m_sum; e_len = 9'(m_cnt); m_to = 1'b0; ph = 4;
                    end else if (wcyc == TO) begin
                        e_sum = '0; e_len = '0; m_to = 1'b1; ph = 4;
                    end
                end
                default: begin
                    chk("res_valid", bus.res_valid, 1);
                    chk("res_sum", bus.res_sum, e_sum);
                    chk("res_len", bus.res_len, e_len);
                    chk("res_words", bus.res_words, m_cnt);
                    chk("res_trunc", bus.res_trunc, m_trunc);
                    chk("res_timeout", bus.res_timeout, m_to);
                    chk("res_no_we", bus.mem_we, 0);
                    chk("res_no_start", bus.vnlp_start, 0);
                    if (bus.res_ready) ph = 0;
                end
            endcase
        end
    end

    task automatic send(input int n, input int base, input bit last_on_final, input bit rnd,
                        output int accepted);
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            int  waited = 0;
            bit  took = 1'b0;
            do begin
                bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_data  = DW'(base + i);
                bus.in_last  = last_on_final && (i == n - 1);
                @(negedge clk);
                took = bus.in_valid && bus.in_ready;
                @(posedge clk); #1;
                waited++;
            end while (!took && waited < 60);
            if (!took) begin
                if (i < 512) chk("word_accept_timeout", i, -1);
                break;
            end
            accepted++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_result(input int hold, output logic [27:0] s, output logic [8:0] l,
                              output logic [9:0] w, output logic tr, output logic tmo);
        int n = 0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        while (!bus.res_valid && n < 300) begin
            @(negedge clk); n++;
        end
        chk("res_valid_arrives", bus.res_valid, 1);
        s = bus.res_sum; l = bus.res_len; w = bus.res_words;
        tr = bus.res_trunc; tmo = bus.res_timeout;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 bus.res_ready = 1'b1;
        @(posedge clk); #1 bus.res_ready = 1'b0;
    endtask

    task automatic expect_res(input string t, input logic [27:0] s, input logic [8:0] l,
                              input logic [9:0] w, input logic tr, input logic tmo,
                              input logic [27:0] es, input logic [8:0] el, input logic [9:0] ew,
                              input logic etr, input logic eto);
        chk({t, "_sum"}, s, es);
        chk({t, "_len"}, l, el);
        chk({t, "_words"}, w, ew);
        chk({t, "_trunc"}, tr, etr);
        chk({t, "_timeout"}, tmo, eto);
    endtask

    initial begin
        logic [27:0] s;
        logic [8:0]  l;
        logic [9:0]  w;
        logic        tr, tmo;
        int          acc, n;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: four words, engine done after 10 cycles
        eng_delay = 10;
        send(4, 1, 1'b1, 1'b0, acc);
        chk("t1_accepted", acc, 4);
        get_result(0, s, l, w, tr, tmo);
        expect_res("t1", s, l, w, tr, tmo, 28'd10, 9'd4, 10'd4, 1'b0, 1'b0);

        // 2: 600 words without last, truncated at 512
        send(600, 1, 1'b0, 1'b0, acc);
        chk("t2_accepted", acc, 512);
        get_result(0, s, l, w, tr, tmo);
        expect_res("t2", s, l, w, tr, tmo, 28'd131328, 9'd0, 10'd512, 1'b1, 1'b0);

        // 3: done left high from run 2 into the first WAIT cycle
        stale_mode = 1'b1; eng_delay = 6;
        send(3, 5, 1'b1, 1'b0, acc);
        get_result(0, s, l, w, tr, tmo);
        expect_res("t3", s, l, w, tr, tmo, 28'd18, 9'd3, 10'd3, 1'b0, 1'b0);
        stale_mode = 1'b0;

        // 4: engine never finishes
        eng_delay = 0;
        send(2, 7, 1'b1, 1'b0, acc);
        get_result(0, s, l, w, tr, tmo);
        expect_res("t4", s, l, w, tr, tmo, 28'd0, 9'd0, 10'd2, 1'b0, 1'b1);

        // 5: random in_valid, result held 7 cycles
        eng_delay = 10;
        send(10, 100, 1'b1, 1'b1, acc);
        chk("t5_accepted", acc, 10);
        get_result(7, s, l, w, tr, tmo);
        expect_res("t5", s, l, w, tr, tmo, 28'd1045, 9'd10, 10'd10, 1'b0, 1'b0);

        // 6: reset during WAIT, then repeat run 1
        send(4, 1, 1'b1, 1'b0, acc);
        n = 0;
        while (!bus.vnlp_start && n < 50) begin
            @(negedge clk); n++;
        end
        chk("t6_start_seen", bus.vnlp_start, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(4, 1, 1'b1, 1'b0, acc);
        get_result(0, s, l, w, tr, tmo);
        expect_res("t6", s, l, w, tr, tmo, 28'd10, 9'd4, 10'd4, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
